// File: rtl/ham_pkg.sv
// Shared constants and types for the Hamming serial receive path.
// Holds the codeword width and the receiver state encoding.
package ham_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 4;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } rx_state_t;
endpackage

// File: rtl/ham_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a reset line looks idle.
module ham_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/ham_rx_deserializer.sv
// Serial-to-parallel receiver for 7-bit Hamming codewords with a
// one-entry valid/ready holding register and overrun tracking.
module ham_rx_deserializer
  import ham_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ser_in,
  input  logic            bit_tick,
  output logic [CW_W-1:0] cw_out,
  output logic            cw_valid,
  input  logic            cw_ready,
  output logic            frame_err,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic [7:0]      frame_cnt
);
  rx_state_t       state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [CW_W-1:0] shreg;
  logic            sample;
  logic            stop_tick;
  logic            offer, bad_stop;
  logic            busy, load, drop;

  ham_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_in),
    .q    (sample)
  );

  assign stop_tick = bit_tick && (state == STOP);
  assign offer     = stop_tick && (sample == STOP_BIT);
  assign bad_stop  = stop_tick && (sample != STOP_BIT);
  assign busy      = cw_valid && !cw_ready;
  assign load      = offer && !busy;
  assign drop      = offer && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bit_tick && !sample) state_nxt = DATA;
      DATA: if (bit_tick && bit_cnt == 3'd6) state_nxt = STOP;
      STOP: if (bit_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_tick) begin
      if (state == IDLE && !sample) begin
        bit_cnt <= '0;
      end else if (state == DATA) begin
        shreg[bit_cnt] <= sample;
        bit_cnt        <= bit_cnt + 3'd1;
      end
    end
  end

  // A word consumed in the same cycle frees the slot for the new offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_out    <= '0;
      cw_valid  <= 1'b0;
      frame_cnt <= '0;
    end else if (load) begin
      cw_out    <= shreg;
      cw_valid  <= 1'b1;
      frame_cnt <= frame_cnt + 8'd1;
    end else if (cw_valid && cw_ready) begin
      cw_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (drop) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ham_rx_deserializer.sv
// Scoreboard bench for ham_rx_deserializer: frame-level stimulus,
// abstract holding-register model, decoupled output monitor.
module tb_ham_rx_deserializer;
  import ham_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ser_in;
  logic            bit_tick;
  logic [CW_W-1:0] cw_out;
  logic            cw_valid;
  logic            cw_ready;
  logic            frame_err;
  logic            overrun;
  logic            ovr_clr;
  logic [7:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ham_rx_deserializer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_in   (ser_in),
    .bit_tick (bit_tick),
    .cw_out   (cw_out),
    .cw_valid (cw_valid),
    .cw_ready (cw_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .frame_cnt(frame_cnt)
  );

  // stop-tick event published by the driver
  logic       ev_stop = 1'b0;
  logic       ev_sbit = 1'b1;
  logic [6:0] ev_word = '0;

  // abstract model state
  logic       m_full, m_ovr, m_ferr;
  logic [7:0] m_cnt;
  int         tot_loads;
  logic [6:0] expq[$];
  logic       m_offer, m_drop;

  int  rdy_mode = 1;
  bit  ham_chk = 0;
  bit  mon_en = 0;
  int  ferr_seen = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic logic [2:0] syn(logic [6:0] c);
    logic s1, s2, s3;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s3 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s3, s2, s1};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_full = 0;
      m_ovr = 0;
      m_ferr = 0;
      m_cnt = 0;
      tot_loads = 0;
      expq.delete();
    end else begin
      m_offer = ev_stop && ev_sbit;
      m_drop = m_offer && m_full && !cw_ready;
      m_ferr = ev_stop && !ev_sbit;
      if (m_offer && !m_drop) begin
        expq.push_back(ev_word);
        m_cnt = m_cnt + 8'd1;
        tot_loads++;
        m_full = 1;
      end else if (m_full && cw_ready) begin
        m_full = 0;
      end
      if (m_drop) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  logic       pv, hs;
  logic [6:0] pw, w;

  always @(posedge clk) begin
    pv = cw_valid;
    hs = cw_valid && cw_ready;
    pw = cw_out;
    #1;
    if (rst_n && mon_en) begin
      chk("cw_valid", cw_valid, m_full);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("overrun", overrun, m_ovr);
      chk("frame_err", frame_err, m_ferr);
      if (frame_err) ferr_seen++;
      if (cw_valid && (!pv || hs)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none",
                   cw_out);
        end else begin
          w = expq.pop_front();
          chk("cw_out", cw_out, w);
          if (ham_chk) chk("syndrome", syn(cw_out), 0);
        end
      end else if (cw_valid && pv) begin
        chk("cw_stable", cw_out, pw);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    ev_stop = 0;
    bit_tick = 0;
    ovr_clr = 0;
    if (rdy_mode == 2) cw_ready = ($urandom_range(3, 0) != 0);
    else cw_ready = (rdy_mode == 1);
  endtask

  task automatic send_slow(logic [6:0] wd, logic sb,
                           int nbits, bit rdy_stop);
    logic [8:0] bits;
    bits = {sb, wd, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      step();
      ser_in = bits[i];
      repeat (3) step();
      step();
      bit_tick = 1;
      if (i == 8) begin
        ev_stop = 1;
        ev_sbit = sb;
        ev_word = wd;
        if (rdy_stop) cw_ready = 1;
      end
    end
    step();
    ser_in = 1;
  endtask

  // one bit per cycle; ticks trail the line by the synchronizer depth
  task automatic send_fast(logic [6:0] wd, logic sb, bit rdy_stop);
    logic [8:0] bits;
    bits = {sb, wd, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step();
      ser_in = (i < 9) ? bits[i] : 1'b1;
      bit_tick = (i >= 2);
      if (i == 10) begin
        ev_stop = 1;
        ev_sbit = sb;
        ev_word = wd;
        if (rdy_stop) cw_ready = 1;
      end
    end
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) begin
      step();
      ser_in = 1;
      bit_tick = $urandom_range(1, 0);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cw_out", cw_out, 0);
    chk("rst_cw_valid", cw_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 0;
    ser_in = 1;
    repeat (2) step();
    @(posedge clk);
    #1;
    chk_reset_vals();
    step();
    rst_n = 1;
  endtask

  int         fe0;
  logic [3:0] d;
  logic [6:0] wr;
  logic       sb;

  initial begin
    rst_n = 0;
    ser_in = 1;
    bit_tick = 0;
    cw_ready = 1;
    ovr_clr = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;

    // clean frame, consumer always ready
    rdy_mode = 1;
    send_slow(7'b1011010, 1'b1, 9, 0);
    repeat (3) step();
    chk("s1_frame_cnt", frame_cnt, 1);
    chk("s1_cw_out", cw_out, 7'b1011010);

    // bad stop bit
    fe0 = ferr_seen;
    send_slow(7'h33, 1'b0, 9, 0);
    repeat (3) step();
    chk("s2_ferr_count", ferr_seen, fe0 + 1);
    chk("s2_frame_cnt", frame_cnt, 1);
    chk("s2_cw_valid", cw_valid, 0);

    // overrun with stalled consumer
    rdy_mode = 0;
    send_fast(7'h15, 1'b1, 0);
    send_fast(7'h2A, 1'b1, 0);
    repeat (2) step();
    chk("s3_cw_out", cw_out, 7'h15);
    chk("s3_overrun", overrun, 1);
    chk("s3_frame_cnt", frame_cnt, 2);
    step();
    ovr_clr = 1;
    step();
    chk("s3_ovr_clr", overrun, 0);

    // consume and offer in the same cycle
    do_reset();
    rdy_mode = 0;
    send_fast(7'h21, 1'b1, 0);
    send_fast(7'h5E, 1'b1, 1);
    repeat (2) step();
    chk("s4_cw_out", cw_out, 7'h5E);
    chk("s4_cw_valid", cw_valid, 1);
    chk("s4_frame_cnt", frame_cnt, 2);
    chk("s4_overrun", overrun, 0);
    rdy_mode = 1;
    repeat (3) step();

    // reset mid-frame
    fe0 = ferr_seen;
    send_slow(7'h2B, 1'b1, 5, 0);
    do_reset();
    send_slow(7'h7F, 1'b1, 9, 0);
    repeat (3) step();
    chk("s5_frame_cnt", frame_cnt, 1);
    chk("s5_cw_out", cw_out, 7'h7F);
    chk("s5_no_ferr", ferr_seen, fe0);

    // randomized traffic through a frame_cnt wrap
    do_reset();
    ham_chk = 1;
    rdy_mode = 2;
    for (int f = 0; f < 600 && tot_loads < 260; f++) begin
      d = 4'($urandom_range(15, 0));
      wr = enc(d);
      sb = ($urandom_range(9, 0) != 0);
      if ($urandom_range(7, 0) == 0) send_slow(wr, sb, 9, 0);
      else send_fast(wr, sb, 0);
      if ($urandom_range(3, 0) == 0)
        idle_ticks($urandom_range(4, 1));
      if ($urandom_range(15, 0) == 0) begin
        step();
        ovr_clr = 1;
      end
    end
    rdy_mode = 1;
    repeat (5) step();
    chk("wrap_frame_cnt", frame_cnt, 32'(tot_loads % 256));
    chk("loads_reached", (tot_loads >= 256), 1);
    chk("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ham_rx_deserializer.md
HAM_RX_DESERIALIZER -- requirements
Module: ham_rx_deserializer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the ser_in synchronizer (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ser_in, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port bit_tick, input, 1 bit: one-cycle strobe marking the sample point of each serial bit.
REQ-006 The block SHALL have port cw_out, output, 7 bits: assembled codeword, feeding the Hamming decoder codeword input directly.
REQ-007 The block SHALL have port cw_valid, output, 1 bit: cw_out holds an unconsumed codeword.
REQ-008 The block SHALL have port cw_ready, input, 1 bit: the consumer accepts cw_out in any cycle where cw_valid and cw_ready are both 1.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a received stop bit is 0.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a completed frame is dropped.
REQ-011 The block SHALL have port ovr_clr, input, 1 bit: synchronous clear of overrun.
REQ-012 The block SHALL have port frame_cnt, output, 8 bits: count of codewords delivered to the holding register, wrapping 255 to 0.

Function
REQ-013 Frame format SHALL be: start bit (0), 7 codeword bits sent bit 0 first, then stop bit (1).
REQ-014 Sampling SHALL use only the synchronized ser_in, and only in cycles where bit_tick is 1.
REQ-015 FSM states SHALL be IDLE, DATA and STOP.
REQ-016 In IDLE, on bit_tick with sampled 0, the block SHALL clear bit_cnt and go to DATA; a sampled 1 SHALL keep it in IDLE.
REQ-017 In DATA, on each bit_tick, the sample SHALL be written into shift register bit [bit_cnt] and bit_cnt SHALL increment.
REQ-018 In DATA, on the tick where bit_cnt equals 6, the FSM SHALL go to STOP; bit_cnt is 3 bits and SHALL never wrap inside a frame.
REQ-019 In STOP, on bit_tick, the FSM SHALL return to IDLE.
REQ-020 In STOP, if the sample is 1, the shift register SHALL be offered to the holding register; if the sample is 0, frame_err SHALL pulse on the next cycle and the word SHALL be discarded.
REQ-021 Latency: cw_valid and cw_out SHALL update in the cycle after the stop-bit tick.
REQ-022 On an offer while the holding register is empty, or is being consumed in the same cycle (cw_valid and cw_ready both 1), the block SHALL load cw_out, hold cw_valid at 1, and increment frame_cnt.
REQ-023 On an offer while cw_valid is 1 and cw_ready is 0, the new word SHALL be dropped, overrun set, cw_out left unchanged, and frame_cnt left unchanged.
REQ-024 On a handshake with no simultaneous offer, cw_valid SHALL go to 0 on the next cycle.
REQ-025 cw_out SHALL stay stable while cw_valid is 1 and not yet accepted.
REQ-026 If ovr_clr and a new overrun event occur in the same cycle, overrun SHALL be 1 (set wins).
REQ-027 bit_tick asserted for consecutive cycles SHALL be legal, with each cycle treated as a separate bit.
REQ-028 The block SHALL contain no combinational path from ser_in to any output.

Reset
REQ-029 While rst_n is 0, the block SHALL force: FSM to IDLE, bit_cnt 0, shift register 0, cw_out 0, cw_valid 0, frame_err 0, overrun 0, frame_cnt 0, synchronizer flops 1 (idle).
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame with no delivery and no frame_err.
REQ-031 After reset release, the first sampled 0 on a bit_tick SHALL start a new frame.

Structure
REQ-032 Shared package ham_pkg SHALL hold CW_W=7, DATA_W=4, STOP_BIT=1'b1 and the rx state enum (IDLE/DATA/STOP).
REQ-033 The synchronizer SHALL be the sub-module ham_sync (parameter STAGES, reset value 1); all other logic SHALL stay in ham_rx_deserializer.

Verification
REQ-034 Scenario: send codeword 7'b1011010 with cw_ready=1 -> cw_out=7'b1011010 and a one-cycle cw_valid pulse the cycle after the stop tick; frame_cnt=1.
REQ-035 Scenario: send a frame with stop bit 0 -> frame_err pulses once, cw_valid stays 0, frame_cnt unchanged.
REQ-036 Scenario: cw_ready=0, send 7'h15 then 7'h2A -> cw_out stays 7'h15, overrun=1, frame_cnt=1; pulse ovr_clr -> overrun=0.
REQ-037 Scenario: cw_ready asserted in the same cycle as the second offer -> cw_out becomes the second word, cw_valid stays 1, frame_cnt=2.
REQ-038 Scenario: assert rst_n=0 after 4 data bits, release, then send 7'h7F -> only 7'h7F is delivered, with no frame_err.
REQ-039 Scenario: deliver 256 frames -> frame_cnt wraps to 0; feeding cw_out to the Hamming decoder gives error=0 for every clean codeword.
